// File: rtl/debug_stepper.sv
// Debug stepper: run/halt/single-step control for a pipeline controller,
// with a PC breakpoint and a counter of clocks on which the pipeline advanced.
module debug_stepper #(
  parameter bit RESET_HALT = 1'b0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_run,
  input  logic             cmd_halt,
  input  logic             cmd_step,
  input  logic [7:0]       step_n,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      inst_addr,
  input  logic             if_valid,
  output logic             debug_en,
  output logic             debug_step,
  output logic             halted,
  output logic             bp_hit,
  output logic [7:0]       steps_left,
  output logic [CNT_W-1:0] adv_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALT    = 2'd1,
    ST_STEP_HI = 2'd2,
    ST_STEP_LO = 2'd3
  } state_t;

  localparam state_t           RESET_STATE = RESET_HALT ? ST_HALT : ST_RUN;
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_stateNext;
  logic [7:0]       r_stepsLeft;
  logic [7:0]       w_stepsNext;
  logic             r_bpHit;
  logic             w_bpHitNext;
  logic             r_stepPrev;
  logic [CNT_W-1:0] r_advCnt;
  logic             w_bpMatch;
  logic             w_stepRise;
  logic             w_advance;

  assign w_bpMatch  = bp_en && if_valid && (inst_addr == bp_addr);
  assign w_stepRise = cmd_step && !r_stepPrev;
  assign w_advance  = (r_state == ST_RUN) || (r_state == ST_STEP_HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RESET_STATE;
      r_stepsLeft <= 8'd0;
      r_bpHit     <= 1'b0;
      r_stepPrev  <= 1'b0;
      r_advCnt    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_stepsLeft <= w_stepsNext;
      r_bpHit     <= w_bpHitNext;
      r_stepPrev  <= cmd_step;
      if (w_advance) begin
        r_advCnt <= r_advCnt + CNT_ONE;
      end
    end
  end

  // cmd_halt outranks a breakpoint, which outranks cmd_run, which outranks a step edge.
  // A breakpoint is only looked at on clocks where the pipeline actually advances.
  always_comb begin
    w_stateNext = r_state;
    w_stepsNext = r_stepsLeft;
    w_bpHitNext = r_bpHit;
    case (r_state)
      ST_RUN: begin
        if (cmd_halt) begin
          w_stateNext = ST_HALT;
        end else if (w_bpMatch) begin
          w_stateNext = ST_HALT;
          w_bpHitNext = 1'b1;
        end
      end
      ST_HALT: begin
        if (!cmd_halt) begin
          if (cmd_run) begin
            w_stateNext = ST_RUN;
            w_bpHitNext = 1'b0;
          end else if (w_stepRise) begin
            w_stateNext = ST_STEP_HI;
            w_stepsNext = (step_n == 8'd0) ? 8'd0 : step_n - 8'd1;
          end
        end
      end
      ST_STEP_HI: begin
        w_stateNext = ST_STEP_LO;
        if (cmd_halt) begin
          w_stepsNext = 8'd0;
        end else if (w_bpMatch) begin
          w_stepsNext = 8'd0;
          w_bpHitNext = 1'b1;
        end
      end
      ST_STEP_LO: begin
        // A zero count here also covers a breakpoint or halt seen on the preceding pulse.
        if (cmd_halt || (r_stepsLeft == 8'd0)) begin
          w_stateNext = ST_HALT;
          w_stepsNext = 8'd0;
        end else begin
          w_stateNext = ST_STEP_HI;
          w_stepsNext = r_stepsLeft - 8'd1;
        end
      end
      default: begin
        w_stateNext = RESET_STATE;
      end
    endcase
  end

  assign debug_en   = (r_state != ST_RUN);
  assign debug_step = (r_state == ST_STEP_HI);
  assign halted     = (r_state == ST_HALT);
  assign bp_hit     = r_bpHit;
  assign steps_left = r_stepsLeft;
  assign adv_cnt    = r_advCnt;

endmodule

// File: tb/tb_debug_stepper.sv
// Scoreboard bench for debug_stepper: two instances (reset to RUN and to HALT) share
// one stimulus stream; a behavioural model predicts every cycle, a monitor compares.
module tb_debug_stepper;

  typedef struct packed {
    logic       running;
    logic       inBurst;
    logic       pulseHigh;
    logic [7:0] left;
    logic       bpHit;
    logic [7:0] adv;
    logic       prevStep;
  } ModelT;

  typedef struct packed {
    logic       debugEn;
    logic       debugStep;
    logic       halted;
    logic       bpHit;
    logic [7:0] stepsLeft;
    logic [7:0] advCnt;
  } ObsT;

  typedef struct packed {
    ObsT d0;
    ObsT d1;
  } PairT;

  logic        clk;
  logic        rst;
  logic        cmdRun;
  logic        cmdHalt;
  logic        cmdStep;
  logic [7:0]  stepN;
  logic        bpEn;
  logic [31:0] bpAddr;
  logic [31:0] instAddr;
  logic        ifValid;

  logic        debugEn   [2];
  logic        debugStep [2];
  logic        halted    [2];
  logic        bpHit     [2];
  logic [7:0]  stepsLeft [2];
  logic [7:0]  advCnt    [2];

  ObsT   obs     [2];
  ObsT   lastObs [2];
  ModelT m       [2];
  PairT  expQ    [$];

  int          nCompared   = 0;
  int          nMismatched = 0;
  int          pulseCnt    = 0;
  logic [31:0] pc          = 32'h0;

  debug_stepper #(.RESET_HALT(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .cmd_run(cmdRun), .cmd_halt(cmdHalt), .cmd_step(cmdStep),
    .step_n(stepN), .bp_en(bpEn), .bp_addr(bpAddr), .inst_addr(instAddr), .if_valid(ifValid),
    .debug_en(debugEn[0]), .debug_step(debugStep[0]), .halted(halted[0]), .bp_hit(bpHit[0]),
    .steps_left(stepsLeft[0]), .adv_cnt(advCnt[0])
  );

  debug_stepper #(.RESET_HALT(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .cmd_run(cmdRun), .cmd_halt(cmdHalt), .cmd_step(cmdStep),
    .step_n(stepN), .bp_en(bpEn), .bp_addr(bpAddr), .inst_addr(instAddr), .if_valid(ifValid),
    .debug_en(debugEn[1]), .debug_step(debugStep[1]), .halted(halted[1]), .bp_hit(bpHit[1]),
    .steps_left(stepsLeft[1]), .adv_cnt(advCnt[1])
  );

  always_comb begin
    obs[0] = {debugEn[0], debugStep[0], halted[0], bpHit[0], stepsLeft[0], advCnt[0]};
    obs[1] = {debugEn[1], debugStep[1], halted[1], bpHit[1], stepsLeft[1], advCnt[1]};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: running / halted / inside a burst, where a burst is a series of
  // one-clock pulses each followed by a one-clock gap.
  function automatic ModelT modelStep(input ModelT cur, input bit resetHalt, input bit r,
                                      input bit run, input bit halt, input bit step,
                                      input logic [7:0] n, input bit match);
    ModelT nx;
    nx = cur;
    if (r) begin
      nx = '0;
      nx.running = !resetHalt;
      return nx;
    end
    nx.prevStep = step;
    if (cur.running || (cur.inBurst && cur.pulseHigh)) nx.adv = cur.adv + 8'd1;
    if (cur.running) begin
      if (halt) nx.running = 1'b0;
      else if (match) begin
        nx.running = 1'b0;
        nx.bpHit   = 1'b1;
      end
    end else if (!cur.inBurst) begin
      if (!halt) begin
        if (run) begin
          nx.running = 1'b1;
          nx.bpHit   = 1'b0;
        end else if (step && !cur.prevStep) begin
          nx.inBurst   = 1'b1;
          nx.pulseHigh = 1'b1;
          nx.left      = (n == 8'd0) ? 8'd0 : n - 8'd1;
        end
      end
    end else if (cur.pulseHigh) begin
      nx.pulseHigh = 1'b0;
      if (halt) nx.left = 8'd0;
      else if (match) begin
        nx.left  = 8'd0;
        nx.bpHit = 1'b1;
      end
    end else begin
      if (halt || cur.left == 8'd0) begin
        nx.inBurst = 1'b0;
        nx.left    = 8'd0;
      end else begin
        nx.pulseHigh = 1'b1;
        nx.left      = cur.left - 8'd1;
      end
    end
    return nx;
  endfunction

  function automatic ObsT expOf(input ModelT cur);
    ObsT o;
    o.debugEn   = !cur.running;
    o.debugStep = cur.inBurst && cur.pulseHigh;
    o.halted    = !cur.running && !cur.inBurst;
    o.bpHit     = cur.bpHit;
    o.stepsLeft = cur.left;
    o.advCnt    = cur.adv;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drives one clock of inputs at the falling edge and queues the predicted outputs.
  task automatic applyStimulus(input bit r, input bit run, input bit halt, input bit step,
                               input logic [7:0] n, input bit bpe, input logic [31:0] bpa,
                               input bit valid);
    bit advancing;
    bit match;
    @(negedge clk);
    rst      = r;
    cmdRun   = run;
    cmdHalt  = halt;
    cmdStep  = step;
    stepN    = n;
    bpEn     = bpe;
    bpAddr   = bpa;
    ifValid  = valid;
    instAddr = pc;
    advancing = m[0].running || (m[0].inBurst && m[0].pulseHigh);
    match     = bpe && valid && (pc == bpa);
    for (int i = 0; i < 2; i++) m[i] = modelStep(m[i], i == 1, r, run, halt, step, n, match);
    expQ.push_back({expOf(m[0]), expOf(m[1])});
    if (!r && advancing) pc = (pc + 32'd4) & 32'h3C;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, 0, 0, 8'd0, 0, 32'h0, 1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    PairT  p;
    ObsT   e;
    string tag;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        p = expQ.pop_front();
        for (int i = 0; i < 2; i++) begin
          e   = (i == 0) ? p.d0 : p.d1;
          tag = $sformatf("dut%0d.", i);
          checkOutput({tag, "debug_en"},   obs[i].debugEn,   e.debugEn);
          checkOutput({tag, "debug_step"}, obs[i].debugStep, e.debugStep);
          checkOutput({tag, "halted"},     obs[i].halted,    e.halted);
          checkOutput({tag, "bp_hit"},     obs[i].bpHit,     e.bpHit);
          checkOutput({tag, "steps_left"}, obs[i].stepsLeft, e.stepsLeft);
          checkOutput({tag, "adv_cnt"},    obs[i].advCnt,    e.advCnt);
          lastObs[i] = obs[i];
        end
        if (obs[1].debugStep === 1'b1) pulseCnt++;
      end
    end
  end

  initial begin
    int          p0;
    logic [7:0]  a0;
    bit          seen;
    for (int i = 0; i < 2; i++) m[i] = '0;
    rst = 1'b1; cmdRun = 0; cmdHalt = 0; cmdStep = 0; stepN = 0;
    bpEn = 0; bpAddr = 0; instAddr = 0; ifValid = 0;

    // Reset values for both RESET_HALT settings.
    applyStimulus(1, 0, 0, 0, 8'd0, 0, 32'h0, 1);
    applyStimulus(1, 0, 0, 0, 8'd0, 0, 32'h0, 1);
    settle();
    checkOutput("reset.halted1",     lastObs[1].halted,    1);
    checkOutput("reset.debug_en1",   lastObs[1].debugEn,   1);
    checkOutput("reset.debug_step1", lastObs[1].debugStep, 0);
    checkOutput("reset.adv_cnt1",    lastObs[1].advCnt,    0);
    checkOutput("reset.halted0",     lastObs[0].halted,    0);

    // A halted instance stays frozen.
    idle(20);
    settle();
    checkOutput("frozen.adv_cnt1", lastObs[1].advCnt, 0);
    checkOutput("frozen.halted1",  lastObs[1].halted, 1);

    // Three-step burst.
    applyStimulus(0, 0, 1, 0, 8'd0, 0, 32'h0, 1);
    settle();
    p0 = pulseCnt;
    a0 = lastObs[1].advCnt;
    applyStimulus(0, 0, 0, 1, 8'd3, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 8'd3, 0, 32'h0, 1);
    idle(7);
    settle();
    checkOutput("burst3.pulses", pulseCnt - p0, 3);
    checkOutput("burst3.adv",    lastObs[1].advCnt - a0, 3);
    checkOutput("burst3.halted", lastObs[1].halted, 1);

    // Ten-step burst cut short by cmd_halt on the third pulse.
    p0 = pulseCnt;
    applyStimulus(0, 0, 0, 1, 8'd10, 0, 32'h0, 1);
    idle(4);
    applyStimulus(0, 0, 1, 0, 8'd10, 0, 32'h0, 1);
    idle(4);
    settle();
    checkOutput("halt3.pulses",     pulseCnt - p0, 3);
    checkOutput("halt3.steps_left", lastObs[1].stepsLeft, 0);
    checkOutput("halt3.halted",     lastObs[1].halted, 1);

    // cmd_run with cmd_halt stays halted; step_n of zero gives one pulse.
    applyStimulus(0, 1, 1, 0, 8'd0, 0, 32'h0, 1);
    settle();
    checkOutput("runhalt.halted", lastObs[1].halted, 1);
    p0 = pulseCnt;
    applyStimulus(0, 0, 0, 1, 8'd0, 0, 32'h0, 1);
    idle(5);
    settle();
    checkOutput("stepzero.pulses", pulseCnt - p0, 1);

    // Breakpoint at 0x10 while running, then resume.
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 32'h10, 1);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus(0, 0, 0, 0, 8'd0, 1, 32'h10, 1);
      settle();
      seen = lastObs[1].halted;
    end
    checkOutput("bp.halted", lastObs[1].halted, 1);
    checkOutput("bp.bp_hit", lastObs[1].bpHit,  1);
    applyStimulus(0, 1, 0, 0, 8'd0, 0, 32'h10, 1);
    settle();
    checkOutput("bp.cleared", lastObs[1].bpHit,  0);
    checkOutput("bp.resumed", lastObs[1].halted, 0);

    // Long run wraps the 8-bit advance counter.
    idle(300);
    applyStimulus(0, 0, 1, 0, 8'd0, 0, 32'h0, 1);

    // Reset in the middle of a five-step burst.
    applyStimulus(0, 0, 0, 1, 8'd5, 0, 32'h0, 1);
    applyStimulus(1, 0, 0, 0, 8'd5, 0, 32'h0, 1);
    settle();
    checkOutput("rstburst.debug_step1", lastObs[1].debugStep, 0);
    checkOutput("rstburst.adv_cnt1",    lastObs[1].advCnt,    0);
    checkOutput("rstburst.steps_left1", lastObs[1].stepsLeft, 0);
    checkOutput("rstburst.halted1",     lastObs[1].halted,    1);
    checkOutput("rstburst.halted0",     lastObs[0].halted,    0);

    // Random traffic against the model.
    begin
      bit stepLvl = 0;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(99) < 30) stepLvl = !stepLvl;
        applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 10,
                      $urandom_range(99) < 10, stepLvl, 8'($urandom_range(5)),
                      $urandom_range(1) == 1, {26'd0, 4'($urandom_range(15)), 2'b00},
                      $urandom_range(99) < 80);
      end
    end
    settle();
    settle();
    if (expQ.size() != 0) checkOutput("scoreboard.drain", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/debug_stepper.md
DEBUG_STEPPER -- requirements
Module: debug_stepper

Interface
Parameters:
REQ-001 RESET_HALT, default 0, meaning: 1 = state after reset is HALT; 0 = state after reset is RUN.
REQ-002 CNT_W, default 32, meaning: width of the advance-cycle counter.

Ports:
REQ-003 clk  in  1  main clock; the block has one clock.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 cmd_run  in  1  level; request free-running execution.
REQ-006 cmd_halt  in  1  level; request suspension.
REQ-007 cmd_step  in  1  level; request a step burst, acted on at its rising edge only.
REQ-008 step_n  in  8  number of pipeline advances per burst; 0 is treated as 1.
REQ-009 bp_en  in  1  breakpoint enable.
REQ-010 bp_addr  in  32  breakpoint PC.
REQ-011 inst_addr  in  32  PC of the instruction in the IF stage.
REQ-012 if_valid  in  1  IF stage valid flag.
REQ-013 debug_en  out  1  drives pipeline-controller debug_en; 1 = pipeline suspended unless stepped.
REQ-014 debug_step  out  1  drives pipeline-controller debug_step; the controller advances one clock per rising edge.
REQ-015 halted  out  1  1 when the state is HALT.
REQ-016 bp_hit  out  1  sticky flag; set by a breakpoint match.
REQ-017 steps_left  out  8  advances remaining in the current burst.
REQ-018 adv_cnt  out  CNT_W  count of clocks on which the pipeline advanced.

Function
REQ-019 The block SHALL implement the FSM states RUN, HALT, STEP_HI and STEP_LO, all registered.
REQ-020 Output decode SHALL be as follows:
- debug_en = (state != RUN).
- debug_step = (state == STEP_HI).
- halted = (state == HALT).
- All of these are direct register decodes with no combinational path from the inputs.
REQ-021 RUN -> HALT SHALL occur on cmd_halt, or on a breakpoint match (bp_en && if_valid && inst_addr == bp_addr). On a breakpoint match, bp_hit is also set the next cycle.
REQ-022 When halting on a breakpoint, the pipeline SHALL have advanced exactly one further clock (the match cycle) before debug_en rises.
REQ-023 HALT -> RUN SHALL occur on cmd_run && !cmd_halt. On this transition bp_hit is cleared.
REQ-024 HALT -> STEP_HI SHALL occur on a cmd_step rising edge (edge detector register reset to 0).
- steps_left is loaded with max(step_n,1) - 1.
- The edge is detected only in HALT; edges seen in RUN, STEP_HI or STEP_LO are discarded.
REQ-025 STEP_HI -> STEP_LO SHALL always occur, after exactly one cycle, so that each debug_step high pulse is one clock wide.
REQ-026 STEP_LO SHALL transition as follows:
- To HALT if steps_left == 0, or cmd_halt, or a breakpoint match occurred during the burst.
- Otherwise to STEP_HI, decrementing steps_left.
- Result: pulse period is 2 clocks and an N-step burst takes 2N clocks.
REQ-027 A breakpoint match during a burst SHALL be evaluated on the STEP_HI cycle. It sets bp_hit, zeroes steps_left, and ends the burst at the next STEP_LO.
REQ-028 cmd_halt during a burst SHALL zero steps_left and return the FSM to HALT at the next STEP_LO; the current pulse always completes (no truncated pulse).
REQ-029 Priority when events coincide SHALL be: rst > cmd_halt > breakpoint > cmd_run > cmd_step.
REQ-030 adv_cnt SHALL increment by 1 on every clock in RUN and on every STEP_HI cycle; it wraps modulo 2^CNT_W without a flag.
REQ-031 bp_hit SHALL remain set until the HALT->RUN transition or reset; a new match while it is already set is harmless.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL load the following on the next cycle:
- state = HALT if RESET_HALT else RUN;
- steps_left = 0, adv_cnt = 0, bp_hit = 0, edge register = 0.
REQ-033 A reset asserted mid-burst SHALL abort the burst immediately; debug_step is 0 on the following cycle.
REQ-034 After reset deasserts, the FSM SHALL act on the inputs of the first non-reset cycle.

Verification
REQ-035 Reset with RESET_HALT=1 -> halted=1, debug_en=1, debug_step=0, adv_cnt=0; the pipeline PC is frozen for 20 cycles.
REQ-036 In HALT, step_n=3 with one cmd_step edge -> debug_step pattern 1,0,1,0,1,0, then HALT; adv_cnt +3; PC advances by exactly 3 fetches.
REQ-037 In RUN, bp_en=1, bp_addr=0x0000_0010 -> halted=1 on the cycle after inst_addr==0x10 && if_valid; bp_hit=1; cmd_run then clears bp_hit and resumes.
REQ-038 step_n=10 with cmd_halt raised on the 3rd STEP_HI -> exactly 3 pulses emitted, then HALT, steps_left=0.
REQ-039 Same-cycle cmd_run and cmd_halt in HALT -> the FSM stays in HALT; step_n=0 with an edge -> exactly 1 pulse.
REQ-040 rst during STEP_HI of a 5-step burst -> debug_step=0 on the next cycle; all counters are 0; the state follows RESET_HALT.
